// File: rtl/int_arbiter.sv
// Multi-source level interrupt arbiter (PLIC-lite): per-source gateways, priority/threshold
// arbitration, and a claim/complete register port with a registered request toward the core.
module int_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_irq_i,
    input  logic               we_i,
    input  logic               re_i,
    input  logic [7:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               int_req_o,
    output logic [4:0]         int_id_o
);

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PENDING = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_e;

    gw_state_e          gw_state_q [NUM_SRC];
    gw_state_e          gw_state_d [NUM_SRC];
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [PRIO_W-1:0]  threshold_q, threshold_d;
    logic [PRIO_W-1:0]  prio_q [NUM_SRC];
    logic [PRIO_W-1:0]  prio_d [NUM_SRC];
    logic [31:0]        rdata_q, rdata_d;
    logic               int_req_q, int_req_d;
    logic [4:0]         int_id_q, int_id_d;

    logic [5:0]         word;
    logic               claim_rd;
    logic               complete_wr;
    logic [NUM_SRC-1:0] pending_vec;
    logic [4:0]         win_id;
    logic [PRIO_W-1:0]  win_prio;
    logic               unused_bits;

    // Bus port: we_i/re_i are single-cycle strobes with no back-pressure; every access
    // completes at the edge it is presented, and read data appears on rdata_o one cycle later.
    assign word        = addr_i[7:2];
    assign claim_rd    = re_i && (word == 6'd2);
    assign complete_wr = we_i && (word == 6'd2);
    assign unused_bits = ^{addr_i[1:0], wdata_i};

    // Ascending scan with strict '>' leaves the lowest ID holding a priority tie.
    always_comb begin
        pending_vec = '0;
        win_id      = '0;
        win_prio    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pending_vec[i] = (gw_state_q[i] == GW_PENDING);
            if (pending_vec[i] && enable_q[i] && (prio_q[i] > threshold_q) && (prio_q[i] > win_prio)) begin
                win_prio = prio_q[i];
                win_id   = 5'(i + 1);
            end
        end
    end

    // Claim and complete both see the pre-edge states, so a same-cycle pair applies cleanly.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            gw_state_d[i] = gw_state_q[i];
            case (gw_state_q[i])
                GW_IDLE:    if (src_irq_i[i]) gw_state_d[i] = GW_PENDING;
                GW_PENDING: if (claim_rd && (win_id == 5'(i + 1))) gw_state_d[i] = GW_CLAIMED;
                GW_CLAIMED: if (complete_wr && (wdata_i[4:0] == 5'(i + 1))) gw_state_d[i] = GW_IDLE;
                default:    gw_state_d[i] = GW_IDLE;
            endcase
        end
    end

    always_comb begin
        enable_d    = enable_q;
        threshold_d = threshold_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            prio_d[i] = prio_q[i];
        end
        if (we_i) begin
            if (word == 6'd0) enable_d = wdata_i[NUM_SRC-1:0];
            if (word == 6'd1) threshold_d = wdata_i[PRIO_W-1:0];
            for (int i = 0; i < NUM_SRC; i++) begin
                if (word == 6'(8 + i)) prio_d[i] = wdata_i[PRIO_W-1:0];
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        if (re_i) begin
            case (word)
                6'd0:    rdata_d = 32'(enable_q);
                6'd1:    rdata_d = 32'(threshold_q);
                6'd2:    rdata_d = 32'(win_id);
                6'd3:    rdata_d = 32'(pending_vec);
                default: rdata_d = '0;
            endcase
            for (int i = 0; i < NUM_SRC; i++) begin
                if (word == 6'(8 + i)) rdata_d = 32'(prio_q[i]);
            end
        end
        int_id_d  = win_id;
        int_req_d = (win_id != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                gw_state_q[i] <= GW_IDLE;
                prio_q[i]     <= '0;
            end
            enable_q    <= '0;
            threshold_q <= '0;
            rdata_q     <= '0;
            int_req_q   <= 1'b0;
            int_id_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                gw_state_q[i] <= gw_state_d[i];
                prio_q[i]     <= prio_d[i];
            end
            enable_q    <= enable_d;
            threshold_q <= threshold_d;
            rdata_q     <= rdata_d;
            int_req_q   <= int_req_d;
            int_id_q    <= int_id_d;
        end
    end

    assign rdata_o   = rdata_q;
    assign int_req_o = int_req_q;
    assign int_id_o  = int_id_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter: drives at negedge, samples at negedge, hand-computed expectations.
module tb_int_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  src_irq_i;
    logic        we_i;
    logic        re_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        int_req_o;
    logic [4:0]  int_id_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rd;

    int_arbiter #(.NUM_SRC(8), .PRIO_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_irq_i (src_irq_i),
        .we_i      (we_i),
        .re_i      (re_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .int_req_o (int_req_o),
        .int_id_o  (int_id_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        we_i = 1'b1; addr_i = a; wdata_i = d;
        @(negedge clk);
        we_i = 1'b0;
    endtask

    task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        re_i = 1'b1; addr_i = a;
        @(negedge clk);
        re_i = 1'b0;
        d = rdata_o;
    endtask

    task automatic reg_rw(input logic [7:0] a, input logic [31:0] wd, output logic [31:0] d);
        @(negedge clk);
        we_i = 1'b1; re_i = 1'b1; addr_i = a; wdata_i = wd;
        @(negedge clk);
        we_i = 1'b0; re_i = 1'b0;
        d = rdata_o;
    endtask

    task automatic pulse_reset(input logic [7:0] src);
        @(negedge clk);
        rst = 1'b1; src_irq_i = src;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; src_irq_i = 8'hFF; we_i = 1'b0; re_i = 1'b0; addr_i = '0; wdata_i = '0;

        // Reset and idle
        repeat (2) @(negedge clk);
        check_eq("rst_int_req", 32'(int_req_o), 32'd0);
        check_eq("rst_int_id", 32'(int_id_o), 32'd0);
        check_eq("rst_rdata", rdata_o, 32'd0);
        rst = 1'b0;
        reg_read(8'h00, rd); check_eq("rst_enable", rd, 32'd0);
        reg_read(8'h04, rd); check_eq("rst_threshold", rd, 32'd0);
        reg_read(8'h20, rd); check_eq("rst_prio1", rd, 32'd0);
        reg_read(8'h3C, rd); check_eq("rst_prio8", rd, 32'd0);
        reg_read(8'h0C, rd); check_eq("rst_pending", rd, 32'hFF);
        check_eq("idle_no_req", 32'(int_req_o), 32'd0);
        reg_read(8'h80, rd); check_eq("unmapped_read", rd, 32'd0);

        // Priority and tie-break
        pulse_reset(8'h00);
        reg_write(8'h00, 32'hFF);
        reg_write(8'h28, 32'd5);
        reg_write(8'h34, 32'd5);
        reg_write(8'h24, 32'd4);
        reg_write(8'h04, 32'd0);
        reg_write(8'h80, 32'hFFFF_FFFF);
        reg_read(8'h28, rd); check_eq("prio3_readback", rd, 32'd5);
        @(negedge clk); src_irq_i = 8'h26;
        @(negedge clk); check_eq("tie_latency", 32'(int_id_o), 32'd0);
        @(negedge clk); check_eq("tie_winner", 32'(int_id_o), 32'd3);
        check_eq("tie_req", 32'(int_req_o), 32'd1);
        reg_read(8'h08, rd); check_eq("claim_3", rd, 32'd3);
        check_eq("id_hold_3", 32'(int_id_o), 32'd3);
        @(negedge clk); check_eq("next_winner_6", 32'(int_id_o), 32'd6);
        reg_read(8'h08, rd); check_eq("claim_6", rd, 32'd6);
        reg_read(8'h08, rd); check_eq("claim_2", rd, 32'd2);
        @(negedge clk); check_eq("all_claimed_req", 32'(int_req_o), 32'd0);

        // Threshold gating
        reg_write(8'h04, 32'd5);
        reg_write(8'h08, 32'd3);
        repeat (3) @(negedge clk);
        check_eq("thr_gate_req", 32'(int_req_o), 32'd0);
        reg_read(8'h0C, rd); check_eq("thr_pending", rd, 32'h04);
        reg_write(8'h04, 32'd4);
        check_eq("thr_lat_req", 32'(int_req_o), 32'd0);
        @(negedge clk); check_eq("thr_open_req", 32'(int_req_o), 32'd1);
        check_eq("thr_open_id", 32'(int_id_o), 32'd3);

        // Same-cycle write and read: read returns pre-write value
        reg_rw(8'h04, 32'd2, rd); check_eq("rw_prewrite", rd, 32'd4);
        reg_read(8'h04, rd); check_eq("rw_postwrite", rd, 32'd2);

        // Same-cycle claim and complete: claim sees ID6 still claimed
        reg_rw(8'h08, 32'd6, rd); check_eq("cc_claim", rd, 32'd3);
        check_eq("cc_id_a", 32'(int_id_o), 32'd3);
        @(negedge clk); check_eq("cc_id_b", 32'(int_id_o), 32'd0);
        @(negedge clk); check_eq("cc_id_c", 32'(int_id_o), 32'd6);

        // Claim/complete with level held
        pulse_reset(8'h00);
        reg_write(8'h00, 32'hFF);
        reg_write(8'h20, 32'd1);
        @(negedge clk); src_irq_i = 8'h01;
        repeat (2) @(negedge clk);
        check_eq("lvl_req", 32'(int_req_o), 32'd1);
        check_eq("lvl_id", 32'(int_id_o), 32'd1);
        reg_read(8'h08, rd); check_eq("lvl_claim", rd, 32'd1);
        @(negedge clk); check_eq("lvl_drop", 32'(int_req_o), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("lvl_stay_low", 32'(int_req_o), 32'd0);
        reg_read(8'h0C, rd); check_eq("lvl_pending_clr", rd, 32'd0);
        reg_write(8'h08, 32'd1);
        check_eq("lvl_cmp_a", 32'(int_req_o), 32'd0);
        @(negedge clk); check_eq("lvl_cmp_b", 32'(int_req_o), 32'd0);
        @(negedge clk); check_eq("lvl_cmp_c", 32'(int_req_o), 32'd1);

        // Illegal completes
        reg_read(8'h08, rd); check_eq("ill_claim", rd, 32'd1);
        reg_write(8'h08, 32'd0);
        reg_write(8'h08, 32'd9);
        reg_write(8'h08, 32'd2);
        repeat (3) @(negedge clk);
        check_eq("ill_req", 32'(int_req_o), 32'd0);
        reg_read(8'h0C, rd); check_eq("ill_pending", rd, 32'd0);
        reg_read(8'h08, rd); check_eq("ill_empty_claim", rd, 32'd0);
        reg_write(8'h08, 32'd1);
        repeat (2) @(negedge clk);
        check_eq("ill_recover", 32'(int_id_o), 32'd1);

        // Mid-operation reset
        pulse_reset(8'h00);
        reg_write(8'h00, 32'hFF);
        reg_write(8'h2C, 32'd3);
        reg_write(8'h30, 32'd2);
        @(negedge clk); src_irq_i = 8'h18;
        repeat (2) @(negedge clk);
        reg_read(8'h08, rd); check_eq("mid_claim4", rd, 32'd4);
        @(negedge clk); check_eq("mid_winner5", 32'(int_id_o), 32'd5);
        pulse_reset(8'h18);
        check_eq("mid_req", 32'(int_req_o), 32'd0);
        check_eq("mid_id", 32'(int_id_o), 32'd0);
        reg_read(8'h08, rd); check_eq("mid_claim_empty", rd, 32'd0);
        reg_read(8'h0C, rd); check_eq("mid_pending", rd, 32'h18);
        reg_read(8'h00, rd); check_eq("mid_enable", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
